ldsync_arb: RTL and testbench
=============================

LDSYNC_ARB -- requirements
Module: ldsync_arb

Interface
REQ-001 Parameter NREQ, default 4: number of requesters, legal range 2..8.
REQ-002 Parameter W, default 6: width of the shared load-enable register word.
REQ-003 Port sys_clk  in  1  the single clock; every flop is rising-edge sys_clk.
REQ-004 Port resetl  in  1  reset, asynchronous assert, active-low.
REQ-005 Port req  in  NREQ  per-requester level load request.
REQ-006 Port din  in  NREQ*W  per-requester load data; requester i uses bits [i*W +: W].
REQ-007 Port gnt  out  NREQ  one-hot, one-cycle acknowledge; high in the cycle the requester's data is loaded.
REQ-008 Port ld  out  1  load enable to the shared register.
REQ-009 Port d  out  W  data to the shared register; valid whenever ld=1.
REQ-010 Port busy  out  1  high in any state other than IDLE.
REQ-011 Port lock  in  NREQ  back-to-back hold request; present only when LDSYNC_ARB_LOCK_EN is defined.

Function
REQ-012 FSM states: IDLE, GRANT, GAP; all outputs are registered.
REQ-013 IDLE: if any req=1, pick the winner round-robin and go to GRANT next cycle; otherwise stay in IDLE.
REQ-014 Round-robin search starts at ptr+1 mod NREQ and picks the first requester with req=1.
REQ-015 GRANT: ld=1, d=din of the winner as sampled at the IDLE decision, gnt[winner]=1, ptr<=winner; then go to GAP.
REQ-016 GAP: one dead cycle with ld=0 and gnt=0; then go to IDLE. Sustained throughput is one load per 3 cycles.
REQ-017 A requester holds req and din stable until it sees gnt, and drops req in the cycle after gnt. If req is still high in IDLE, it is a new request.
REQ-018 A requester whose req falls before it is granted is not granted; no partial load occurs.
REQ-019 Outside GRANT: ld=0, gnt=0, and d holds its last value.
REQ-020 gnt is never multi-hot; exactly one gnt bit is high when ld=1.

Reset
REQ-021 While resetl=0: state=IDLE, ptr=NREQ-1 (requester 0 wins first), ld=0, d=0, gnt=0, busy=0, and the lock counter is 0.
REQ-022 Reset asserted mid-GRANT clears ld and gnt asynchronously; that load counts as not done.
REQ-023 After resetl deasserts, the first grant occurs no earlier than the second rising edge.

Configuration
REQ-024 With LDSYNC_ARB_LOCK_EN defined, a lock-continue is taken in GRANT when lock[winner]=1, req[winner]=1 and run<15. The FSM then goes to GRANT again with the same winner, skips GAP, and samples new din, giving one load per cycle.
REQ-025 The run counter (4 bits) increments on each lock-continue and clears on leaving GRANT. When run reaches 15, the FSM forces GAP so other requesters are not starved.
REQ-026 Without LDSYNC_ARB_LOCK_EN: the lock port and run counter are absent, and behaviour is exactly REQ-012..REQ-020.

Structure
REQ-027 The shared package ldsync_pkg holds the state encoding (IDLE=0, GRANT=1, GAP=2), the run limit constant 15, and the default W=6.
REQ-028 The round-robin picker is a combinational sub-module, rr_pick. Its input is the req vector and ptr; its outputs are the one-hot winner and a valid bit.
REQ-029 The shared register itself is not part of this block.

Verification
REQ-030 Reset, then req=0001 with din0=6'h2A: ld=1 with d=6'h2A and gnt=0001 on the 2nd cycle after req, busy high for 2 cycles.
REQ-031 req=1111 held, each requester dropping req after its own gnt: gnt order is 0,1,2,3, with grants 3 cycles apart.
REQ-032 After requester 2 is granted, req=0101: requester 0 wins next (ptr wraps past 3).
REQ-033 req1 rises, then falls one cycle later before any grant, with no other requests: no ld and no gnt; FSM returns to IDLE.
REQ-034 resetl pulsed low during GRANT: ld and gnt go to 0 immediately; after release, ptr=NREQ-1 and requester 0 has priority.
REQ-035 With LOCK_EN, lock0=1 and req=0011 held: 16 consecutive loads to requester 0, then GAP, then requester 1 is granted.

Source files
------------

// File: rtl/ldsync_pkg.sv
// Shared definitions for the ldsync_arb load-synchronising arbiter:
// FSM state encoding, lock run limit and default data width.
package ldsync_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [3:0] RUN_LIMIT = 4'd15;
    localparam int         W_DEFAULT = 6;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester with req=1 searching
// upward from ptr+1 (mod NREQ); winner is one-hot, valid flags a hit.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] winner,
    output logic            valid
);

    int idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!valid && req[idx]) begin
                winner[idx] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ldsync_arb.sv
// Round-robin arbiter feeding one shared load-enable register (IDLE/GRANT/GAP).
// Optional feature macro LDSYNC_ARB_LOCK_EN adds back-to-back lock runs.
module ldsync_arb
    import ldsync_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = W_DEFAULT
) (
    input  logic                sys_clk,
    input  logic                resetl,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*W-1:0]   din,
`ifdef LDSYNC_ARB_LOCK_EN
    input  logic [NREQ-1:0]     lock,
`endif
    output logic [NREQ-1:0]     gnt,
    output logic                ld,
    output logic [W-1:0]        d,
    output logic                busy
);

    localparam int PW = $clog2(NREQ);

    state_t            state_reg, state_next;
    logic [PW-1:0]     ptr_reg, ptr_next;
    logic [NREQ-1:0]   win_reg, win_next;
    logic [W-1:0]      wdat_reg, wdat_next;
    logic              ld_reg, ld_next;
    logic [NREQ-1:0]   gnt_reg, gnt_next;
    logic [W-1:0]      d_reg, d_next;
    logic              busy_reg, busy_next;

    logic [NREQ-1:0]   pick_oh;
    logic              pick_valid;
    logic [W-1:0]      pick_slice [NREQ];
    logic [W-1:0]      pick_data;
    logic [PW-1:0]     win_idx;
    logic              win_req;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req    (req),
        .ptr    (ptr_reg),
        .winner (pick_oh),
        .valid  (pick_valid)
    );

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_pick_mux
        assign pick_slice[gi] = pick_oh[gi] ? din[gi*W +: W] : '0;
    end

    always_comb begin
        pick_data = '0;
        win_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            pick_data = pick_data | pick_slice[i];
            if (win_reg[i]) win_idx = PW'(i);
        end
    end

    // The winner must still be requesting when its load is issued.
    assign win_req = |(req & win_reg);

`ifdef LDSYNC_ARB_LOCK_EN
    logic [W-1:0]      hold_slice [NREQ];
    logic [W-1:0]      hold_data;
    logic              win_lock;
    logic [3:0]        run_reg, run_next;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_hold_mux
        assign hold_slice[gi] = win_reg[gi] ? din[gi*W +: W] : '0;
    end

    always_comb begin
        hold_data = '0;
        for (int i = 0; i < NREQ; i++) hold_data = hold_data | hold_slice[i];
    end

    assign win_lock = |(lock & win_reg);
`endif

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        win_next   = win_reg;
        wdat_next  = wdat_reg;
        ld_next    = 1'b0;
        gnt_next   = '0;
        d_next     = d_reg;
`ifdef LDSYNC_ARB_LOCK_EN
        run_next   = run_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (pick_valid) begin
                    state_next = GRANT;
                    win_next   = pick_oh;
                    wdat_next  = pick_data;
                end
            end
            GRANT: begin
                if (win_req) begin
                    ld_next    = 1'b1;
                    gnt_next   = win_reg;
                    d_next     = wdat_reg;
                    ptr_next   = win_idx;
                    state_next = GAP;
`ifdef LDSYNC_ARB_LOCK_EN
                    run_next   = '0;
                    if (win_lock && (run_reg < RUN_LIMIT)) begin
                        state_next = GRANT;
                        run_next   = run_reg + 4'd1;
                        wdat_next  = hold_data;
                    end
`endif
                end else begin
                    // Request withdrawn before its load: abandon without loading.
                    state_next = IDLE;
`ifdef LDSYNC_ARB_LOCK_EN
                    run_next   = '0;
`endif
                end
            end
            GAP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
            state_reg <= IDLE;
            ptr_reg   <= PW'(NREQ - 1);
            win_reg   <= '0;
            wdat_reg  <= '0;
            ld_reg    <= 1'b0;
            gnt_reg   <= '0;
            d_reg     <= '0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            win_reg   <= win_next;
            wdat_reg  <= wdat_next;
            ld_reg    <= ld_next;
            gnt_reg   <= gnt_next;
            d_reg     <= d_next;
            busy_reg  <= busy_next;
        end
    end

`ifdef LDSYNC_ARB_LOCK_EN
    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) run_reg <= '0;
        else         run_reg <= run_next;
    end
`endif

    assign gnt  = gnt_reg;
    assign ld   = ld_reg;
    assign d    = d_reg;
    assign busy = busy_reg;

endmodule

// File: tb/tb_ldsync_arb.sv
// Self-checking bench for ldsync_arb: cycle table for single requests and
// aborts, then a scoreboard-driven requester model for round-robin sequences.
module tb_ldsync_arb;

    localparam int NREQ = 4;
    localparam int W    = 6;

    logic              sys_clk = 1'b0;
    logic              resetl  = 1'b0;
    logic [NREQ-1:0]   req     = '0;
    logic [NREQ*W-1:0] din     = '0;
    logic [NREQ-1:0]   gnt;
    logic              ld;
    logic [W-1:0]      d;
    logic              busy;
`ifdef LDSYNC_ARB_LOCK_EN
    logic [NREQ-1:0]   lock = '0;
`endif

    ldsync_arb #(.NREQ(NREQ), .W(W)) dut (
        .sys_clk (sys_clk),
        .resetl  (resetl),
        .req     (req),
        .din     (din),
`ifdef LDSYNC_ARB_LOCK_EN
        .lock    (lock),
`endif
        .gnt     (gnt),
        .ld      (ld),
        .d       (d),
        .busy    (busy)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct {
        logic [3:0] req;
        logic [5:0] d0;
        logic [5:0] d1;
        logic       ld;
        logic [3:0] gnt;
        logic [5:0] d;
        logic       busy;
    } vec_t;

    typedef struct {
        logic [3:0] gnt;
        logic [5:0] d;
    } exp_t;

    vec_t            tbl [9];
    exp_t            exp_q [$];
    int              ld_times [$];
    logic            mon_en  = 1'b0;
    logic            auto_en = 1'b0;
    logic [NREQ-1:0] pending = '0;
    logic [NREQ-1:0] gnt_seen = '0;
    int              remaining [NREQ];

    task automatic push(input logic [3:0] g, input logic [5:0] dv);
        exp_t e;
        e.gnt = g;
        e.d   = dv;
        exp_q.push_back(e);
    endtask

    task automatic drain(input string name, input int max_cyc);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cyc) begin
            @(negedge sys_clk);
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (3) @(negedge sys_clk);
    endtask

    // Requester model: holds req until it has seen its grant(s), drops it the cycle after.
    initial begin
        forever begin
            @(posedge sys_clk);
            #1;
            if (auto_en) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (gnt_seen[i] && pending[i]) begin
                        if (remaining[i] <= 1) pending[i] = 1'b0;
                        else remaining[i] = remaining[i] - 1;
                    end
                end
                req = pending;
            end
        end
    end

    // Output monitor and scoreboard comparison.
    initial begin
        exp_t e;
        forever begin
            @(negedge sys_clk);
            gnt_seen = gnt;
            if (mon_en) begin
                if (ld) begin
                    ld_times.push_back(cyc);
                    check("gnt_onehot", 32'($onehot(gnt)), 32'd1);
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_ld: got ld=1 gnt=%b d=0x%0h, required no load", gnt, d);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_gnt", 32'(gnt), 32'(e.gnt));
                        check("sb_d", 32'(d), 32'(e.d));
                    end
                end else begin
                    check("idle_gnt", 32'(gnt), 32'd0);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NREQ; i++) remaining[i] = 1;
        //             req      d0     d1     ld    gnt      d      busy
        tbl[0] = '{4'b0001, 6'h2A, 6'h00, 1'b0, 4'b0000, 6'h00, 1'b0};
        tbl[1] = '{4'b0001, 6'h2A, 6'h00, 1'b0, 4'b0000, 6'h00, 1'b1};
        tbl[2] = '{4'b0001, 6'h2A, 6'h00, 1'b1, 4'b0001, 6'h2A, 1'b1};
        tbl[3] = '{4'b0000, 6'h2A, 6'h00, 1'b0, 4'b0000, 6'h2A, 1'b0};
        tbl[4] = '{4'b0000, 6'h00, 6'h00, 1'b0, 4'b0000, 6'h2A, 1'b0};
        tbl[5] = '{4'b0010, 6'h00, 6'h15, 1'b0, 4'b0000, 6'h2A, 1'b0};
        tbl[6] = '{4'b0000, 6'h00, 6'h15, 1'b0, 4'b0000, 6'h2A, 1'b1};
        tbl[7] = '{4'b0000, 6'h00, 6'h00, 1'b0, 4'b0000, 6'h2A, 1'b0};
        tbl[8] = '{4'b0000, 6'h00, 6'h00, 1'b0, 4'b0000, 6'h2A, 1'b0};

        // Reset state.
        repeat (3) @(negedge sys_clk);
        check("rst_ld", 32'(ld), 32'd0);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_d", 32'(d), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        resetl = 1'b1;

        // Single request and withdrawn request, cycle by cycle.
        for (int i = 0; i < 9; i++) begin
            @(posedge sys_clk);
            #1;
            req = tbl[i].req;
            din = {6'h00, 6'h00, tbl[i].d1, tbl[i].d0};
            @(negedge sys_clk);
            check($sformatf("tbl%0d_ld", i), 32'(ld), 32'(tbl[i].ld));
            check($sformatf("tbl%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
            check($sformatf("tbl%0d_d", i), 32'(d), 32'(tbl[i].d));
            check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
        end

        // Reset asserted during the load cycle of requester 2.
        @(posedge sys_clk);
        #1;
        req = 4'b0100;
        din = {6'h00, 6'h33, 6'h00, 6'h00};
        @(posedge sys_clk);
        @(posedge sys_clk);
        #2;
        check("pre_rst_ld", 32'(ld), 32'd1);
        check("pre_rst_gnt", 32'(gnt), 32'b0100);
        resetl = 1'b0;
        #1;
        check("async_rst_ld", 32'(ld), 32'd0);
        check("async_rst_gnt", 32'(gnt), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_d", 32'(d), 32'd0);
        @(negedge sys_clk);
        req = '0;
        din = '0;
        @(negedge sys_clk);
        resetl = 1'b1;

        // All four request at once: 0,1,2,3 three cycles apart (requester 0 first after reset).
        mon_en  = 1'b1;
        auto_en = 1'b1;
        ld_times.delete();
        din = {6'h13, 6'h12, 6'h11, 6'h10};
        pending = 4'b1111;
        push(4'b0001, 6'h10);
        push(4'b0010, 6'h11);
        push(4'b0100, 6'h12);
        push(4'b1000, 6'h13);
        drain("rr1111_drain", 60);
        check("rr1111_count", 32'(ld_times.size()), 32'd4);
        for (int i = 1; i < ld_times.size(); i++)
            check($sformatf("rr1111_spacing%0d", i), 32'(ld_times[i] - ld_times[i-1]), 32'd3);

        // Requester 2 granted, then req=0101: pointer wraps past 3 so 0 wins.
        din[2*W +: W] = 6'h22;
        pending = 4'b0100;
        push(4'b0100, 6'h22);
        drain("solo2_drain", 20);
        din[0 +: W]   = 6'h30;
        din[2*W +: W] = 6'h32;
        pending = 4'b0101;
        push(4'b0001, 6'h30);
        push(4'b0100, 6'h32);
        drain("wrap0101_drain", 30);

`ifdef LDSYNC_ARB_LOCK_EN
        // Lock run: 16 back-to-back loads for requester 0, a gap, then requester 1.
        ld_times.delete();
        lock = 4'b0001;
        din[0 +: W] = 6'h05;
        din[W +: W] = 6'h06;
        remaining[0] = 16;
        pending = 4'b0011;
        for (int i = 0; i < 16; i++) push(4'b0001, 6'h05);
        push(4'b0010, 6'h06);
        drain("lock_drain", 100);
        check("lock_count", 32'(ld_times.size()), 32'd17);
        if (ld_times.size() == 17) begin
            for (int i = 1; i < 16; i++)
                check($sformatf("lock_spacing%0d", i), 32'(ld_times[i] - ld_times[i-1]), 32'd1);
            check("lock_gap", 32'(ld_times[16] - ld_times[15]), 32'd3);
        end
        lock = '0;
`endif

        mon_en  = 1'b0;
        auto_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
